// File: rtl/ram_arbiter2.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM.
// Each transaction runs IDLE -> ACCESS -> RESP. The winner is chosen round-robin or by fixed priority.
module ram_arbiter2 #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              wr_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic              resp_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic              resp_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;
    logic              cur_b_q, cur_b_d;
    logic              cur_wr_q, cur_wr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic              resp_a_q, resp_a_d, resp_b_q, resp_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic              grant_b;

    // B wins when it is the only requester, or on a tie when A was served last.
    always_comb begin
        grant_b = req_b && (!req_a || ((FIXED_PRIO == 0) && !last_b_q));
    end

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        cur_b_d    = cur_b_q;
        cur_wr_d   = cur_wr_q;
        mem_en_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        resp_a_d   = 1'b0;
        resp_b_d   = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d    = ACCESS;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = grant_b ? wr_b : wr_a;
                    mem_addr_d = grant_b ? addr_b : addr_a;
                    mem_din_d  = grant_b ? wdata_b : wdata_a;
                    ack_a_d    = !grant_b;
                    ack_b_d    = grant_b;
                    last_b_d   = grant_b;
                    cur_b_d    = grant_b;
                    cur_wr_d   = grant_b ? wr_b : wr_a;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                state_d  = IDLE;
                resp_a_d = !cur_b_q;
                resp_b_d = cur_b_q;
                // Writes leave rdata untouched; mem_dout then holds pre-write data.
                if (!cur_wr_q) begin
                    if (cur_b_q) begin
                        rdata_b_d = mem_dout;
                    end else begin
                        rdata_a_d = mem_dout;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            cur_b_q    <= 1'b0;
            cur_wr_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            resp_a_q   <= 1'b0;
            resp_b_q   <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            cur_b_q    <= cur_b_d;
            cur_wr_q   <= cur_wr_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            resp_a_q   <= resp_a_d;
            resp_b_q   <= resp_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign resp_a   = resp_a_q;
    assign resp_b   = resp_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign mem_en   = mem_en_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = (state_q != IDLE);

endmodule
